mips_mem_arbiter: RTL and testbench

- Shares one unified single-port memory between the MIPS instruction-fetch requester (I) and the load/store requester (D).
- Arbitrates between the two, runs the memory handshake, and returns read data and completion to the winner.
- Drives a stall output that freezes PC and register writeback while any access is outstanding.
- Adds a timeout so a hung memory cannot lock the core.

---
 rtl/mips_mem_arbiter_pkg.sv | 19 +
 rtl/mips_mem_arbiter_if.sv | 50 +++++
 rtl/mips_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mips_mem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// Shared encodings for the MIPS unified-memory arbiter.
package mips_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_t;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter.
interface mips_mem_arbiter_if
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   localparam int BE_W = DATA_W / 8;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_done;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [BE_W-1:0]   d_be;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;

   logic              err;
   logic              stall;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   // arbiter side
   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
             mem_ready, mem_rdata,
      output i_done, i_rdata, d_done, d_rdata, err, stall,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

   // core requesters + memory side
   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
             mem_ready, mem_rdata,
      input  i_done, i_rdata, d_done, d_rdata, err, stall,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

endinterface

// File: rtl/mips_mem_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one single-port memory,
// with round-robin on contention and a BUSY timeout.
module mips_mem_arbiter
   import mips_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   mips_mem_arbiter_if.master  bus
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   gnt_t              last_gnt_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              mem_req_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [BE_W-1:0]   mem_be_q;
   logic              i_done_q, d_done_q, err_q;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

   logic elig_i, elig_d;
   logic grant_i, grant_d;
   logic fin_ok, fin_to;

   // a requester in its own done cycle is not eligible, so it cannot be re-granted
   assign elig_i = bus.i_req & ~i_done_q;
   assign elig_d = bus.d_req & ~d_done_q;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state, grant and completion decode
   always_comb begin
      state_d = state_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      fin_ok  = 1'b0;
      fin_to  = 1'b0;
      case (state_q)
         IDLE: begin
            if (elig_i && (!elig_d || last_gnt_q == GNT_D)) begin
               grant_i = 1'b1;
               state_d = BUSY_I;
            end else if (elig_d) begin
               grant_d = 1'b1;
               state_d = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            // mem_ready wins over a simultaneous expiry
            if (bus.mem_ready) begin
               fin_ok  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               fin_to  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // memory-side registers, timeout counter, completion and read data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_gnt_q  <= GNT_D;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         err_q    <= 1'b0;
         if (grant_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
            last_gnt_q  <= GNT_I;
            cnt_q       <= '0;
         end else if (grant_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_be_q    <= bus.d_be;
            last_gnt_q  <= GNT_D;
            cnt_q       <= '0;
         end else if (fin_ok || fin_to) begin
            mem_req_q <= 1'b0;
            err_q     <= fin_to;
            if (state_q == BUSY_I) begin
               i_done_q  <= 1'b1;
               i_rdata_q <= fin_ok ? bus.mem_rdata : '0;
            end else begin
               d_done_q  <= 1'b1;
               d_rdata_q <= fin_ok ? bus.mem_rdata : '0;
            end
         end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.i_done    = i_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.err       = err_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.stall     = (bus.i_req & ~i_done_q) | (bus.d_req & ~d_done_q);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter (built with TIMEOUT=8).
module tb_mips_mem_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // advance to the middle of the next cycle
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.i_req = 0; bus.i_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
      bus.mem_ready = 0; bus.mem_rdata = '0;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      cyc(); cyc();
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
      n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
      n_cmp++; if ({bus.i_done, bus.d_done, bus.err} !== 3'b000) begin n_err++; $display("FAIL reset_done_err got %b want 000", {bus.i_done, bus.d_done, bus.err}); end
      n_cmp++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", {bus.i_rdata, bus.d_rdata}); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall); end
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_fetch();
      // cycle 0
      bus.i_req = 1; bus.i_addr = 32'h0040_0000;
      #1;
      n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall0 got %b want 1", bus.stall); end
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL fetch_req0 got %b want 0", bus.mem_req); end
      cyc(); // cycle 1
      n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_req1 got %b want 1", bus.mem_req); end
      n_cmp++; if (bus.mem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL fetch_addr got %h want 00400000", bus.mem_addr); end
      n_cmp++; if ({bus.mem_we, bus.mem_be} !== 5'b0_1111) begin n_err++; $display("FAIL fetch_we_be got %b want 01111", {bus.mem_we, bus.mem_be}); end
      bus.mem_ready = 1; bus.mem_rdata = 32'h2008_0005;
      cyc(); // cycle 2
      bus.mem_ready = 0; bus.mem_rdata = 32'hFFFF_FFFF;
      n_cmp++; if (bus.i_done !== 1'b1) begin n_err++; $display("FAIL fetch_done got %b want 1", bus.i_done); end
      n_cmp++; if (bus.i_rdata !== 32'h2008_0005) begin n_err++; $display("FAIL fetch_rdata got %h want 20080005", bus.i_rdata); end
      n_cmp++; if ({bus.err, bus.mem_req, bus.d_done} !== 3'b000) begin n_err++; $display("FAIL fetch_err_req2 got %b want 000", {bus.err, bus.mem_req, bus.d_done}); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall2 got %b want 0", bus.stall); end
      bus.i_req = 0;
      cyc(); // cycle 3
      n_cmp++; if ({bus.i_done, bus.mem_req} !== 2'b00) begin n_err++; $display("FAIL fetch_after got %b want 00", {bus.i_done, bus.mem_req}); end
      n_cmp++; if (bus.i_rdata !== 32'h2008_0005) begin n_err++; $display("FAIL fetch_rdata_hold got %h want 20080005", bus.i_rdata); end
   endtask

   task automatic test_both();
      pulse_reset();
      // cycle 0
      bus.i_req = 1; bus.i_addr = 32'h0040_0004;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1001_0004;
      bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
      cyc(); // cycle 1
      n_cmp++; if ({bus.mem_req, bus.mem_we} !== 2'b10) begin n_err++; $display("FAIL both_first_req_we got %b want 10", {bus.mem_req, bus.mem_we}); end
      n_cmp++; if (bus.mem_addr !== 32'h0040_0004) begin n_err++; $display("FAIL both_first_addr got %h want 00400004", bus.mem_addr); end
      bus.mem_ready = 1; bus.mem_rdata = 32'h8C08_0000;
      cyc(); // cycle 2
      bus.mem_ready = 0;
      n_cmp++; if ({bus.i_done, bus.mem_req, bus.stall} !== 3'b101) begin n_err++; $display("FAIL both_idone_stall got %b want 101", {bus.i_done, bus.mem_req, bus.stall}); end
      bus.i_req = 0;
      cyc(); // cycle 3
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b11_0011) begin n_err++; $display("FAIL both_d_req_we_be got %b want 110011", {bus.mem_req, bus.mem_we, bus.mem_be}); end
      n_cmp++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL both_d_wdata got %h want deadbeef", bus.mem_wdata); end
      n_cmp++; if (bus.mem_addr !== 32'h1001_0004) begin n_err++; $display("FAIL both_d_addr got %h want 10010004", bus.mem_addr); end
      n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL both_stall3 got %b want 1", bus.stall); end
      bus.mem_ready = 1; bus.mem_rdata = 32'h0;
      cyc(); // cycle 4
      bus.mem_ready = 0;
      n_cmp++; if ({bus.d_done, bus.err, bus.stall} !== 3'b100) begin n_err++; $display("FAIL both_ddone got %b want 100", {bus.d_done, bus.err, bus.stall}); end
      bus.d_req = 0; bus.d_we = 0;
      cyc();
      n_cmp++; if ({bus.d_done, bus.mem_req} !== 2'b00) begin n_err++; $display("FAIL both_after got %b want 00", {bus.d_done, bus.mem_req}); end
   endtask

   task automatic test_alternate();
      logic [3:0] exp_i;
      exp_i = 4'b0101; // k=0: I, k=1: D, k=2: I, k=3: D
      bus.i_req = 1; bus.i_addr = 32'h0000_0100;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0200;
      cyc();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({bus.mem_req, bus.mem_addr} !== {1'b1, (exp_i[k] ? 32'h100 : 32'h200)}) begin
            n_err++; $display("FAIL alt_grant%0d got req=%b addr=%h want req=1 addr=%h", k, bus.mem_req, bus.mem_addr, exp_i[k] ? 32'h100 : 32'h200);
         end
         bus.mem_ready = 1; bus.mem_rdata = 32'hA000_0000 + k;
         cyc();
         bus.mem_ready = 0;
         n_cmp++;
         if ({bus.i_done, bus.d_done, bus.mem_req} !== {exp_i[k], ~exp_i[k], 1'b0}) begin
            n_err++; $display("FAIL alt_done%0d got %b want %b", k, {bus.i_done, bus.d_done, bus.mem_req}, {exp_i[k], ~exp_i[k], 1'b0});
         end
         n_cmp++;
         if ((exp_i[k] ? bus.i_rdata : bus.d_rdata) !== 32'hA000_0000 + k) begin
            n_err++; $display("FAIL alt_rdata%0d got %h want %h", k, exp_i[k] ? bus.i_rdata : bus.d_rdata, 32'hA000_0000 + k);
         end
         if (k == 3) begin bus.i_req = 0; bus.d_req = 0; end
         cyc();
      end
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL alt_idle got %b want 0", bus.mem_req); end
   endtask

   task automatic test_timeout();
      int bad;
      bad = 0;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0300;
      cyc();
      for (int c = 1; c <= 8; c++) begin
         if ({bus.mem_req, bus.d_done, bus.err} !== 3'b100) bad++;
         cyc();
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL to_busy_window got %0d bad cycles want 0", bad); end
      n_cmp++; if ({bus.d_done, bus.err, bus.mem_req} !== 3'b110) begin n_err++; $display("FAIL to_expire got %b want 110", {bus.d_done, bus.err, bus.mem_req}); end
      n_cmp++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL to_rdata got %h want 0", bus.d_rdata); end
      bus.d_req = 0;
      cyc();
      n_cmp++; if ({bus.d_done, bus.err, bus.mem_req} !== 3'b000) begin n_err++; $display("FAIL to_after got %b want 000", {bus.d_done, bus.err, bus.mem_req}); end
   endtask

   task automatic test_drop();
      int dones, moved;
      dones = 0; moved = 0;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1234_5678;
      cyc(); // cycle 1
      n_cmp++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h1234_5678}) begin n_err++; $display("FAIL drop_grant got req=%b addr=%h want req=1 addr=12345678", bus.mem_req, bus.mem_addr); end
      bus.d_req = 0; bus.d_addr = 32'hFFFF_0000;
      for (int c = 2; c <= 8; c++) begin
         cyc();
         bus.mem_ready = 0;
         if (bus.d_done) dones++;
         if (c <= 4 && bus.mem_addr !== 32'h1234_5678) moved++;
         if (c == 4) begin bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_F00D; end
      end
      n_cmp++; if (moved !== 0) begin n_err++; $display("FAIL drop_addr_stable got %0d changes want 0", moved); end
      n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL drop_done_count got %0d want 1", dones); end
      n_cmp++; if (bus.d_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL drop_rdata got %h want 0badf00d", bus.d_rdata); end
   endtask

   task automatic test_async_reset();
      bus.i_req = 1; bus.i_addr = 32'h0040_0010;
      cyc();
      n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL ar_busy got %b want 1", bus.mem_req); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if ({bus.mem_req, bus.i_done} !== 2'b00) begin n_err++; $display("FAIL ar_immediate got %b want 00", {bus.mem_req, bus.i_done}); end
      n_cmp++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL ar_rdata_clr got %h want 0", bus.d_rdata); end
      cyc();
      n_cmp++; if ({bus.mem_req, bus.i_done, bus.err} !== 3'b000) begin n_err++; $display("FAIL ar_held got %b want 000", {bus.mem_req, bus.i_done, bus.err}); end
      reset = 1'b1;
      cyc();
      n_cmp++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0040_0010}) begin n_err++; $display("FAIL ar_regrant got req=%b addr=%h want req=1 addr=00400010", bus.mem_req, bus.mem_addr); end
      bus.mem_ready = 1; bus.mem_rdata = 32'h2402_0001;
      cyc();
      bus.mem_ready = 0;
      n_cmp++; if ({bus.i_done, bus.err} !== 2'b10 || bus.i_rdata !== 32'h2402_0001) begin n_err++; $display("FAIL ar_serve got done=%b err=%b rdata=%h want 1 0 24020001", bus.i_done, bus.err, bus.i_rdata); end
      bus.i_req = 0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_both();
      test_alternate();
      test_timeout();
      test_drop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
